// File: rtl/delay_fifo_if.sv
// delay_fifo_if: handshake bundle for the show-ahead delay FIFO.
// master drives the upstream side; slave is the FIFO.
interface delay_fifo_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  logic                     flush;
  logic                     in_valid;
  logic [WIDTH-1:0]         in_data;
  logic                     in_ready;
  logic                     out_valid;
  logic [WIDTH-1:0]         out_data;
  logic                     out_ready;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;

  modport master (
    output flush,
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  count,
    input  overflow
  );

  modport slave (
    input  flush,
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output count,
    output overflow
  );
endinterface

// File: rtl/delay_fifo.sv
// delay_fifo: show-ahead FIFO behind a delay line.
// Drops input when full and records it in a sticky overflow flag.
module delay_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input logic        clock,
  input logic        reset_n,
  delay_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             ovf;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic drop;

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);

  assign push = bus.in_valid & ~full & ~bus.flush;
  assign pop  = ~empty & bus.out_ready & ~bus.flush;
  assign drop = bus.in_valid & full & ~bus.flush;

  assign bus.in_ready  = ~full;
  assign bus.out_valid = ~empty;
  assign bus.out_data  = empty ? '0 : mem[rd_ptr];
  assign bus.count     = cnt;
  assign bus.overflow  = ovf;

  // storage is intentionally left unreset
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (drop) begin
        ovf <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_delay_fifo.sv
// tb_delay_fifo: queue-model scoreboard for delay_fifo.
// Inputs change just after posedge; monitor samples on negedge.
module tb_delay_fifo;
  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  delay_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) fif ();

  delay_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (fif)
  );

  always #5 clock = ~clock;

  logic [WIDTH-1:0] exp_q [$];
  int               m_cnt = 0;
  bit               m_ovf = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp,
               $time);
    end
  endtask

  // reference: occupancy and overflow from the stated rules
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exp_q.delete();
      m_cnt = 0;
      m_ovf = 1'b0;
    end else if (fif.flush) begin
      exp_q.delete();
      m_cnt = 0;
      m_ovf = 1'b0;
    end else begin
      automatic bit acc = fif.in_valid && (m_cnt < DEPTH);
      automatic bit tak = (m_cnt != 0) && fif.out_ready;
      if (fif.in_valid && m_cnt >= DEPTH) m_ovf = 1'b1;
      if (acc) exp_q.push_back(fif.in_data);
      m_cnt = m_cnt + int'(acc) - int'(tak);
    end
  end

  // monitor: status compare and in-order data pop
  always @(negedge clock) begin
    chk("count", int'(fif.count), m_cnt);
    chk("in_ready", int'(fif.in_ready), int'(m_cnt < DEPTH));
    chk("out_valid", int'(fif.out_valid), int'(m_cnt != 0));
    chk("overflow", int'(fif.overflow), int'(m_ovf));
    if (!fif.out_valid) begin
      chk("out_data_idle", int'(fif.out_data), 0);
    end else if (exp_q.size() == 0) begin
      chk("out_data_unexpected", 1, 0);
    end else begin
      chk("out_data", int'(fif.out_data), int'(exp_q[0]));
      if (fif.out_ready && !fif.flush && reset_n) begin
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic cyc(input bit v, input int d, input bit r, input bit f);
    fif.in_valid  = v;
    fif.in_data   = WIDTH'(d);
    fif.out_ready = r;
    fif.flush     = f;
    @(posedge clock);
    #2;
  endtask

  initial begin
    fif.in_valid  = 1'b0;
    fif.in_data   = '0;
    fif.out_ready = 1'b0;
    fif.flush     = 1'b0;
    #1;
    chk("rst_count", int'(fif.count), 0);
    chk("rst_in_ready", int'(fif.in_ready), 1);
    chk("rst_out_data", int'(fif.out_data), 0);
    repeat (3) @(posedge clock);
    #2;
    reset_n = 1'b1;

    // three pushes with consumer stalled
    cyc(1, 1, 0, 0);
    cyc(1, 2, 0, 0);
    cyc(1, 3, 0, 0);
    chk("fill3_count", int'(fif.count), 3);
    chk("fill3_head", int'(fif.out_data), 1);
    chk("fill3_ready", int'(fif.in_ready), 1);

    // overfill then drain
    cyc(0, 0, 0, 1);
    for (int i = 5; i <= 9; i++) cyc(1, i, 0, 0);
    chk("ovf_count", int'(fif.count), 4);
    chk("ovf_ready", int'(fif.in_ready), 0);
    chk("ovf_flag", int'(fif.overflow), 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0);
    chk("drain_count", int'(fif.count), 0);
    chk("ovf_sticky", int'(fif.overflow), 1);

    // streaming with consumer always ready
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      cyc(1, i, 1, 0);
      chk("stream_head", int'(fif.out_data), i);
      checks++;
      if (fif.count > 1) begin
        failures++;
        $display("FAIL stream_count: got %0d expected <=1", fif.count);
      end
    end
    cyc(0, 0, 1, 0);

    // flush beats push and pop
    cyc(1, 10, 0, 0);
    cyc(1, 11, 0, 0);
    cyc(1, 12, 1, 1);
    chk("flush_count", int'(fif.count), 0);
    chk("flush_valid", int'(fif.out_valid), 0);
    chk("flush_ovf", int'(fif.overflow), 0);

    // full with pop and push: pop wins, input dropped
    for (int i = 0; i < 4; i++) cyc(1, i + 4, 0, 0);
    cyc(1, 15, 1, 0);
    chk("fullpop_count", int'(fif.count), 3);
    chk("fullpop_ovf", int'(fif.overflow), 1);
    chk("fullpop_head", int'(fif.out_data), 5);

    // async reset between edges
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, i + 1, 0, 0);
    fif.in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("arst_count", int'(fif.count), 0);
    chk("arst_valid", int'(fif.out_valid), 0);
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    cyc(1, 12, 0, 0);
    chk("post_rst_count", int'(fif.count), 1);
    chk("post_rst_head", int'(fif.out_data), 12);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
          1'($urandom_range(0, 2) != 0), ($urandom_range(0, 63) == 0));
    end

    @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/delay_fifo.md
DELAY_FIFO -- requirements
Module: delay_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the data width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the entry count; it is a power of two and at least 2.
REQ-003 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush  input  1  synchronous discard of all entries.
REQ-006 SHALL have port in_valid  input  1  the upstream delay-line output is valid this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  the upstream delay-line output data.
REQ-008 SHALL have port in_ready  output  1  the FIFO can accept an entry this cycle.
REQ-009 SHALL have port out_valid  output  1  the head entry is presented.
REQ-010 SHALL have port out_data  output  WIDTH  the head entry data.
REQ-011 SHALL have port out_ready  input  1  the consumer takes the head this cycle.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  the current occupancy.
REQ-013 SHALL have port overflow  output  1  sticky flag: an entry was dropped.

Function
REQ-014 SHALL accept a push on a rising edge when in_valid=1, in_ready=1 and flush=0, writing in_data at the write pointer.
REQ-015 SHALL perform a pop on a rising edge when out_valid=1, out_ready=1 and flush=0, advancing the read pointer.
REQ-016 SHALL drive in_ready = (count < DEPTH), independent of out_ready; there is no full-state pass-through.
REQ-017 SHALL drive out_valid = (count != 0) and out_data = the head entry combinationally (show-ahead), so latency is 1 cycle from push edge to out_valid=1.
REQ-018 SHALL drive out_data to all zeros when out_valid=0.
REQ-019 SHALL update count as +1 for push only, -1 for pop only, and unchanged for simultaneous push and pop.
REQ-020 SHALL wrap the read and write pointers modulo DEPTH with no gap and no reordering; output order SHALL equal accepted input order.
REQ-021 SHALL treat an in_valid=1 while in_ready=0 (full) as a drop: data discarded, state unchanged, and overflow set to 1 on that edge.
REQ-022 SHALL, when full with in_valid=1 and out_ready=1, pop the head and drop the input (in_ready is 0 that cycle); count becomes DEPTH-1.
REQ-023 SHALL, when empty with in_valid=1, push only; there is no same-cycle bypass to out_data.
REQ-024 SHALL give flush=1 priority over push and pop: on that edge pointers and count go to 0 and overflow is cleared; in_data is not captured.
REQ-025 SHALL hold overflow at 1 until flush or reset, with no other clearing path.
REQ-026 SHALL keep storage contents unreset; only pointers, count and overflow carry reset values.

Reset
REQ-027 SHALL, while reset_n=0 and regardless of clock, force count=0, both pointers to 0, overflow=0, out_valid=0, out_data=0 and in_ready=1.
REQ-028 SHALL, when reset_n asserts mid-operation with entries held, discard them immediately (asynchronously), and no stale entry SHALL reappear after release.
REQ-029 SHALL accept the first push on the first rising edge after reset_n returns to 1.

Verification
REQ-030 SHALL be verified by: reset, then push 1,2,3 on consecutive edges with out_ready=0 -> count=3, out_data=1, out_valid=1, in_ready=1.
REQ-031 SHALL be verified by: with DEPTH=4, push 5,6,7,8,9 with out_ready=0 -> count=4, in_ready=0, overflow=1, and a drain yields 5,6,7,8 only.
REQ-032 SHALL be verified by: push 0..15 continuously with out_ready=1 -> out_data sequence 0..15 each one cycle after push, count stays at most 1, and the pointers wrap 4 times.
REQ-033 SHALL be verified by: with count=2 (A,B), assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, overflow=0.
REQ-034 SHALL be verified by: with count=3, drive reset_n low between clock edges -> count=0 and out_valid=0 before the next edge; release, push C -> out_data=C.
REQ-035 SHALL be verified by: when full, drive in_valid=1 and out_ready=1 -> head popped, input dropped, count=3, overflow=1.
